// File: rtl/bcd_scan_counter_if.sv
// Bus bundle for the BCD scan counter: count controls in,
// count status and the scanned digit stream out.
interface bcd_scan_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  scan_start;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic                  load_err;
    logic                  A;
    logic                  B;
    logic                  C;
    logic                  D;
    logic [2:0]            digit_idx;
    logic                  digit_valid;
    logic                  scan_busy;
    logic                  scan_done;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        output scan_start,
        input  count,
        input  wrap,
        input  load_err,
        input  A,
        input  B,
        input  C,
        input  D,
        input  digit_idx,
        input  digit_valid,
        input  scan_busy,
        input  scan_done
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        input  scan_start,
        output count,
        output wrap,
        output load_err,
        output A,
        output B,
        output C,
        output D,
        output digit_idx,
        output digit_valid,
        output scan_busy,
        output scan_done
    );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with load and wrap strobe, plus a
// snapshot scanner that streams the count MSD first on A..D.
module bcd_scan_counter #(
    parameter int DIGITS = 4
) (
    input logic              clk,
    input logic              rst,
    bcd_scan_counter_if.slave bus
);
    localparam int         W       = 4 * DIGITS;
    localparam logic [2:0] IDX_TOP = 3'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         lerr_q;
    logic         lerr_d;

    state_t       state_q;
    state_t       state_d;
    logic [2:0]   idx_q;
    logic [2:0]   idx_d;
    logic [W-1:0] shadow_q;
    logic [W-1:0] shadow_d;

    logic         scan_last;
    logic [3:0]   dig_o;
    logic [2:0]   idx_o;
    logic         valid_o;
    logic         done_o;

    always_comb begin : count_next
        logic [3:0] dig;
        logic       carry;
        dig    = 4'd0;
        carry  = 1'b1;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (bus.load) begin
            // Out-of-range digits are squashed so the count stays legal BCD
            for (int i = 0; i < DIGITS; i++) begin
                dig = bus.load_val[4*i +: 4];
                if (dig > 4'd9) begin
                    cnt_d[4*i +: 4] = 4'd0;
                    lerr_d          = 1'b1;
                end else begin
                    cnt_d[4*i +: 4] = dig;
                end
            end
        end else if (bus.en) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = cnt_q[4*i +: 4];
                if (carry) begin
                    if (bus.up) begin
                        if (dig == 4'd9) begin
                            cnt_d[4*i +: 4] = 4'd0;
                        end else begin
                            cnt_d[4*i +: 4] = dig + 4'd1;
                            carry           = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            cnt_d[4*i +: 4] = 4'd9;
                        end else begin
                            cnt_d[4*i +: 4] = dig - 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
            // A carry/borrow out of the top digit is the roll-over
            wrap_d = carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    assign scan_last = (state_q == SCAN) && (idx_q == 3'd0);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    state_d  = SCAN;
                    idx_d    = IDX_TOP;
                    shadow_d = cnt_q;
                end
            end
            SCAN: begin
                // The last digit cycle may chain straight into a new scan
                if (scan_last) begin
                    if (bus.scan_start) begin
                        idx_d    = IDX_TOP;
                        shadow_d = cnt_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        dig_o   = 4'd0;
        idx_o   = 3'd0;
        valid_o = 1'b0;
        done_o  = 1'b0;
        if (state_q == SCAN) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx_q == 3'(i)) begin
                    dig_o = shadow_q[4*i +: 4];
                end
            end
            idx_o   = idx_q;
            valid_o = 1'b1;
            done_o  = scan_last;
        end
    end

    assign bus.count       = cnt_q;
    assign bus.wrap        = wrap_q;
    assign bus.load_err    = lerr_q;
    assign bus.A           = dig_o[3];
    assign bus.B           = dig_o[2];
    assign bus.C           = dig_o[1];
    assign bus.D           = dig_o[0];
    assign bus.digit_idx   = idx_o;
    assign bus.digit_valid = valid_o;
    assign bus.scan_busy   = valid_o;
    assign bus.scan_done   = done_o;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: decimal-integer model with a digit queue,
// per-cycle comparison plus directed literal expectations.
module tb_bcd_scan_counter;
    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_scan_counter_if #(.DIGITS(DIGITS)) bus ();

    bcd_scan_counter #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   m_val  = 0;
    logic m_wrap = 1'b0;
    logic m_lerr = 1'b0;
    int   m_q[$];
    int   nv;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: count is a plain integer; a scan is a queue of (idx,digit)
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val  = 0;
            m_wrap = 1'b0;
            m_lerr = 1'b0;
            m_q.delete();
        end else begin
            nv     = m_val;
            m_wrap = 1'b0;
            m_lerr = 1'b0;
            if (bus.load) begin
                int p;
                int d;
                nv = 0;
                p  = 1;
                for (int i = 0; i < DIGITS; i++) begin
                    d = int'(bus.load_val[4*i +: 4]);
                    if (d > 9) begin
                        d      = 0;
                        m_lerr = 1'b1;
                    end
                    nv = nv + d * p;
                    p  = p * 10;
                end
            end else if (bus.en) begin
                if (bus.up) begin
                    if (m_val == MAXV) begin
                        nv     = 0;
                        m_wrap = 1'b1;
                    end else begin
                        nv = m_val + 1;
                    end
                end else begin
                    if (m_val == 0) begin
                        nv     = MAXV;
                        m_wrap = 1'b1;
                    end else begin
                        nv = m_val - 1;
                    end
                end
            end
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (bus.scan_start && m_q.size() == 0) begin
                int p;
                p = 1000;
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    m_q.push_back(i * 16 + (m_val / p) % 10);
                    p = p / 10;
                end
            end
            m_val = nv;
        end
    end

    always @(negedge clk) begin
        logic       ev;
        logic [2:0] ei;
        logic [3:0] ed;
        ev = (m_q.size() > 0);
        ei = ev ? 3'(m_q[0] / 16) : 3'd0;
        ed = ev ? 4'(m_q[0] % 16) : 4'd0;
        chk("m_count", 32'(bus.count), 32'(to_bcd(m_val)));
        chk("m_wrap", 32'(bus.wrap), 32'(m_wrap));
        chk("m_load_err", 32'(bus.load_err), 32'(m_lerr));
        chk("m_valid", 32'(bus.digit_valid), 32'(ev));
        chk("m_busy", 32'(bus.scan_busy), 32'(ev));
        chk("m_idx", 32'(bus.digit_idx), 32'(ei));
        chk("m_abcd", 32'({bus.A, bus.B, bus.C, bus.D}), 32'(ed));
        chk("m_done", 32'(bus.scan_done), 32'(m_q.size() == 1));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] scan_word();
        return {1'b0, bus.digit_idx, bus.A, bus.B, bus.C, bus.D};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en         = 1'b0;
        bus.up         = 1'b0;
        bus.load       = 1'b0;
        bus.load_val   = '0;
        bus.scan_start = 1'b0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_valid", 32'(bus.digit_valid), 32'h0);
        rst = 1'b0;

        // Async reset between edges, with a scan in flight
        bus.load     = 1'b1;
        bus.load_val = 16'h4321;
        step();
        bus.load       = 1'b0;
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("pre_rst_count", 32'(bus.count), 32'h4321);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_valid", 32'(bus.digit_valid), 32'h0);
        chk("arst_busy", 32'(bus.scan_busy), 32'h0);
        chk("arst_abcd", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Increment through all-9s
        bus.load     = 1'b1;
        bus.load_val = 16'h9998;
        step();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        bus.up   = 1'b1;
        step();
        chk("inc_9999", 32'(bus.count), 32'h9999);
        chk("inc_9999_wrap", 32'(bus.wrap), 32'h0);
        step();
        chk("inc_0000", 32'(bus.count), 32'h0000);
        chk("inc_0000_wrap", 32'(bus.wrap), 32'h1);
        step();
        chk("inc_0001", 32'(bus.count), 32'h0001);
        chk("inc_0001_wrap", 32'(bus.wrap), 32'h0);

        // Decrement through all-0s, then an illegal load
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 16'h0000;
        step();
        bus.load = 1'b0;
        bus.en   = 1'b1;
        bus.up   = 1'b0;
        step();
        chk("dec_9999", 32'(bus.count), 32'h9999);
        chk("dec_9999_wrap", 32'(bus.wrap), 32'h1);
        step();
        chk("dec_9998", 32'(bus.count), 32'h9998);
        chk("dec_9998_wrap", 32'(bus.wrap), 32'h0);
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 16'h12A4;
        step();
        chk("bad_load_count", 32'(bus.count), 32'h1204);
        chk("bad_load_err", 32'(bus.load_err), 32'h1);
        bus.load = 1'b0;
        step();
        chk("bad_load_err_clr", 32'(bus.load_err), 32'h0);

        // Idle scan of 0937
        bus.load     = 1'b1;
        bus.load_val = 16'h0937;
        step();
        bus.load       = 1'b0;
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("scan0937_d3", 32'(scan_word()), 32'h30);
        chk("scan0937_done3", 32'(bus.scan_done), 32'h0);
        step();
        chk("scan0937_d2", 32'(scan_word()), 32'h29);
        step();
        chk("scan0937_d1", 32'(scan_word()), 32'h13);
        step();
        chk("scan0937_d0", 32'(scan_word()), 32'h07);
        chk("scan0937_done0", 32'(bus.scan_done), 32'h1);
        step();
        chk("scan0937_idle", 32'(bus.digit_valid), 32'h0);

        // Scan while counting, ignored mid-scan request, chained scan
        bus.load     = 1'b1;
        bus.load_val = 16'h0100;
        step();
        bus.load       = 1'b0;
        bus.en         = 1'b1;
        bus.up         = 1'b1;
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("run_d3", 32'(scan_word()), 32'h30);
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("run_d2", 32'(scan_word()), 32'h21);
        step();
        chk("run_d1", 32'(scan_word()), 32'h10);
        chk("run_count", 32'(bus.count), 32'h0103);
        step();
        chk("run_d0", 32'(scan_word()), 32'h00);
        chk("run_done", 32'(bus.scan_done), 32'h1);
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("chain_valid", 32'(bus.digit_valid), 32'h1);
        chk("chain_d3", 32'(scan_word()), 32'h30);
        step();
        step();
        step();
        chk("chain_d0", 32'(scan_word()), 32'h04);
        bus.en = 1'b0;
        step();

        // Reset abort during idx 2
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        step();
        chk("abort_at_d2", 32'(bus.digit_idx), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(bus.digit_valid), 32'h0);
        chk("abort_busy", 32'(bus.scan_busy), 32'h0);
        chk("abort_abcd", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h0);
        chk("abort_done", 32'(bus.scan_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 16'h5678;
        step();
        bus.load       = 1'b0;
        bus.scan_start = 1'b1;
        step();
        bus.scan_start = 1'b0;
        chk("post_rst_d3", 32'(scan_word()), 32'h35);
        repeat (3) step();
        chk("post_rst_d0", 32'(scan_word()), 32'h08);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
